// File: rtl/servant_wb_loader.sv
// Byte-stream to Wishbone RAM loader: packs bytes little-endian into 32-bit words
// and writes each word with one single-beat Wishbone cycle.
module servant_wb_loader #(
  parameter int          aw        = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          TIMEOUT   = 255
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic          i_start,
  input  logic [aw:0]   i_len,
  input  logic [7:0]    i_byte_dat,
  input  logic          i_byte_vld,
  output logic          o_byte_rdy,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [aw-1:2] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic          i_wb_ack
);

  // state   | meaning
  // IDLE    | waiting for i_start
  // COLLECT | accepting stream bytes into the word buffer
  // WRITE   | Wishbone write in flight, waiting for ack or timeout
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;

  localparam logic [aw-1:2] BASE_W = BASE_ADDR[aw-1:2];

  logic [1:0]  state;
  logic [aw:0] remaining;
  logic [1:0]  lane;
  logic [15:0] wd_cnt;

  // Word buffer, byte selects and word pointer are the bus outputs themselves,
  // so they hold still for the whole WRITE phase without extra copies.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state      <= S_IDLE;
      remaining  <= '0;
      lane       <= '0;
      wd_cnt     <= '0;
      o_byte_rdy <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_wb_adr   <= '0;
      o_wb_dat   <= '0;
      o_wb_sel   <= '0;
      o_wb_we    <= 1'b0;
      o_wb_cyc   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            if (i_len != '0) begin
              remaining  <= i_len;
              o_wb_adr   <= BASE_W;
              lane       <= '0;
              o_wb_sel   <= '0;
              o_err      <= 1'b0;
              o_busy     <= 1'b1;
              o_byte_rdy <= 1'b1;
              state      <= S_COLLECT;
            end else begin
              o_done <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (i_byte_vld && o_byte_rdy) begin
            o_wb_dat[8*lane +: 8] <= i_byte_dat;
            o_wb_sel[lane]        <= 1'b1;
            lane                  <= lane + 2'd1;
            remaining             <= remaining - (aw+1)'(1);
            if (lane == 2'd3 || remaining == (aw+1)'(1)) begin
              o_byte_rdy <= 1'b0;
              o_wb_cyc   <= 1'b1;
              o_wb_we    <= 1'b1;
              wd_cnt     <= 16'(TIMEOUT - 1);
              state      <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (i_wb_ack) begin
            o_wb_cyc <= 1'b0;
            o_wb_we  <= 1'b0;
            o_wb_adr <= o_wb_adr + (aw-2)'(1);
            lane     <= '0;
            o_wb_sel <= '0;
            if (remaining == '0) begin
              o_done <= 1'b1;
              o_busy <= 1'b0;
              state  <= S_IDLE;
            end else begin
              o_byte_rdy <= 1'b1;
              state      <= S_COLLECT;
            end
          end else if (wd_cnt == '0) begin
            // Target never answered: abandon the load, unread bytes stay in the source.
            o_err    <= 1'b1;
            o_wb_cyc <= 1'b0;
            o_wb_we  <= 1'b0;
            o_wb_sel <= '0;
            o_done   <= 1'b1;
            o_busy   <= 1'b0;
            state    <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servant_wb_loader.sv
// Randomized bench for servant_wb_loader: word-level write model, registered-ack RAM.
module tb_servant_wb_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, vld = 1'b0, ack = 1'b0, ack_en = 1'b1, sel_b = 1'b0;
  logic [16:0] len = '0;
  logic [7:0]  bdat = '0;
  logic        pre_en = 1'b0;
  logic [13:0] pre_adr = '0;
  logic [31:0] pre_dat = '0;

  logic a_rdy, a_busy, a_done, a_err, a_we, a_cyc;
  logic b_rdy, b_busy, b_done, b_err, b_we, b_cyc;
  logic [13:0] a_adr, b_adr;
  logic [31:0] a_dat, b_dat;
  logic [3:0]  a_sel, b_sel;

  // Instance A: defaults. Instance B: BASE_ADDR=0x10, TIMEOUT=4. Only one is active at a time.
  servant_wb_loader dut_a (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_start(start & ~sel_b), .i_len(len),
    .i_byte_dat(bdat), .i_byte_vld(vld & ~sel_b), .o_byte_rdy(a_rdy), .o_busy(a_busy),
    .o_done(a_done), .o_err(a_err), .o_wb_adr(a_adr), .o_wb_dat(a_dat), .o_wb_sel(a_sel),
    .o_wb_we(a_we), .o_wb_cyc(a_cyc), .i_wb_ack(ack & ~sel_b));

  servant_wb_loader #(.BASE_ADDR(32'h10), .TIMEOUT(4)) dut_b (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_start(start & sel_b), .i_len(len),
    .i_byte_dat(bdat), .i_byte_vld(vld & sel_b), .o_byte_rdy(b_rdy), .o_busy(b_busy),
    .o_done(b_done), .o_err(b_err), .o_wb_adr(b_adr), .o_wb_dat(b_dat), .o_wb_sel(b_sel),
    .o_wb_we(b_we), .o_wb_cyc(b_cyc), .i_wb_ack(ack & sel_b));

  logic rdy, busy, done, err, we, cyc;
  logic [13:0] adr;
  logic [31:0] dat;
  logic [3:0]  wsel;
  assign rdy  = sel_b ? b_rdy  : a_rdy;
  assign busy = sel_b ? b_busy : a_busy;
  assign done = sel_b ? b_done : a_done;
  assign err  = sel_b ? b_err  : a_err;
  assign we   = sel_b ? b_we   : a_we;
  assign cyc  = sel_b ? b_cyc  : a_cyc;
  assign adr  = sel_b ? b_adr  : a_adr;
  assign dat  = sel_b ? b_dat  : a_dat;
  assign wsel = sel_b ? b_sel  : a_sel;

  // servant_ram-like target: registered ack, writes on every cyc&we cycle
  logic [31:0] mem [0:16383];
  always @(posedge clk) begin
    ack <= cyc & ~ack & ack_en;
    if (pre_en) mem[pre_adr] <= pre_dat;
    else if (cyc & we)
      for (int j = 0; j < 4; j++) if (wsel[j]) mem[adr][8*j +: 8] <= dat[8*j +: 8];
  end

  typedef struct { logic [13:0] adr; logic [31:0] dat; logic [3:0] sel; } wr_t;
  wr_t exp_q[$];
  logic [7:0] src [0:63];
  int total = 0, passed = 0, done_cnt = 0, wr_cnt = 0, cyc_hi = 0;
  logic [3:0] last_sel = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m;
    for (int j = 0; j < 4; j++) m[8*j +: 8] = {8{s[j]}};
    return m;
  endfunction

  // Expected writes of a whole load: bytes grouped four at a time from the base word.
  task automatic model_load(input int base, input int n);
    for (int k = 0; k * 4 < n; k++) begin
      wr_t w;
      w.adr = 14'((base >> 2) + k);
      w.sel = '0;
      w.dat = '0;
      for (int j = 0; j < 4; j++)
        if (k * 4 + j < n) begin
          w.sel[j] = 1'b1;
          w.dat[8*j +: 8] = src[k*4 + j];
        end
      exp_q.push_back(w);
    end
  endtask

  logic p_cyc = 1'b0, p_hs = 1'b0, p_done = 1'b0;
  logic [13:0] p_adr = '0;
  logic [31:0] p_dat = '0;
  logic [3:0]  p_sel = '0;
  always @(negedge clk) begin
    if (rst) begin
      p_cyc = 1'b0; p_hs = 1'b0; p_done = 1'b0;
    end else begin
      chk("rdy_during_cyc", 32'(rdy & cyc), 32'd0);
      chk("busy", 32'(busy), 32'(rdy | cyc));
      chk("we", 32'(we), 32'(cyc));
      if (p_done) chk("done_width", 32'(done), 32'd0);
      if (cyc && p_cyc && !p_hs) begin
        chk("adr_stable", 32'(adr), 32'(p_adr));
        chk("sel_stable", 32'(wsel), 32'(p_sel));
        chk("dat_stable", dat & bmask(wsel), p_dat & bmask(wsel));
      end
      if (cyc && ack) begin
        if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_adr", 32'(adr), 32'(e.adr));
          chk("wr_sel", 32'(wsel), 32'(e.sel));
          chk("wr_dat", dat & bmask(e.sel), e.dat);
        end
        last_sel = wsel;
        wr_cnt++;
      end
      if (done) done_cnt++;
      if (cyc) cyc_hi++;
      p_cyc = cyc; p_hs = cyc && ack; p_done = done;
      p_adr = adr; p_dat = dat; p_sel = wsel;
    end
  end

  // Start a load of n bytes from src[] and stream them with pct% valid density.
  task automatic run_load(input int n, input int pct, input int mid_at, input bit rst_in_write,
                          output int acc_to_done);
    int idx = 0, first = -1;
    bit finished = 0;
    acc_to_done = -1;
    @(negedge clk); start = 1'b1; len = 17'(n);
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        finished = 1;
        if (first >= 0) acc_to_done = i - first;
        break;
      end
      if (rst_in_write && cyc) begin
        rst = 1'b1; vld = 1'b0; finished = 1;
        break;
      end
      start = (i == mid_at);
      if (i == mid_at) len = 17'd3;
      vld  = (idx < n) && ($urandom_range(99) < pct);
      bdat = vld ? src[idx] : 8'($urandom);
      if (vld && rdy) begin
        if (first < 0) first = i;
        idx++;
      end
      @(negedge clk);
    end
    start = 1'b0; vld = 1'b0;
    if (!finished) chk("load_completes", 32'd0, 32'd1);
  endtask

  initial begin
    int t, d0, w0, c0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(a_rdy), 0);   chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0); chk("rst_err", 32'(a_err), 0);
    chk("rst_cyc", 32'(a_cyc), 0);   chk("rst_we", 32'(a_we), 0);
    chk("rst_adr", 32'(a_adr), 0);   chk("rst_sel", 32'(a_sel), 0);
    chk("rst_dat", a_dat, 0);        chk("rst_b_cyc", 32'(b_cyc), 0);
    rst = 1'b0;

    // 8 bytes back to back into base 0
    for (int i = 0; i < 8; i++) src[i] = 8'(i + 1);
    model_load(0, 8);
    d0 = done_cnt; w0 = wr_cnt;
    run_load(8, 100, -1, 0, t);
    chk("accept_to_done", 32'(t), 32'd12);
    repeat (2) @(negedge clk);
    chk("t1_mem0", mem[0], 32'h04030201);
    chk("t1_mem1", mem[1], 32'h08070605);
    chk("t1_writes", 32'(wr_cnt - w0), 32'd2);
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t1_q_empty", 32'(exp_q.size()), 0);

    // base 0x10, partial last word, preloaded upper half must survive
    sel_b = 1'b1;
    @(negedge clk); pre_en = 1'b1; pre_adr = 14'd5; pre_dat = 32'h12345678;
    @(negedge clk); pre_en = 1'b0;
    src[0] = 8'hAA; src[1] = 8'hBB; src[2] = 8'hCC; src[3] = 8'hDD; src[4] = 8'hEE; src[5] = 8'hFF;
    model_load(16, 6);
    run_load(6, 100, -1, 0, t);
    repeat (2) @(negedge clk);
    chk("t2_mem4", mem[4], 32'hDDCCBBAA);
    chk("t2_mem5", mem[5], 32'h1234FFEE);
    chk("t2_q_empty", 32'(exp_q.size()), 0);

    // 5 random bytes with gappy valid
    sel_b = 1'b0;
    for (int i = 0; i < 5; i++) src[i] = 8'($urandom);
    model_load(0, 5);
    run_load(5, 50, -1, 0, t);
    chk("t3_last_sel", 32'(last_sel), 32'h1);
    chk("t3_q_empty", 32'(exp_q.size()), 0);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(13, 1);
      for (int i = 0; i < n; i++) src[i] = 8'($urandom);
      model_load(0, n);
      run_load(n, $urandom_range(100, 30), -1, 0, t);
      chk("rand_q_empty", 32'(exp_q.size()), 0);
    end

    // ack never comes: timeout after 4 cycles on B
    sel_b = 1'b1; ack_en = 1'b0;
    for (int i = 0; i < 4; i++) src[i] = 8'($urandom);
    d0 = done_cnt; c0 = cyc_hi;
    run_load(4, 100, -1, 0, t);
    repeat (2) @(negedge clk);
    chk("to_cyc_cycles", 32'(cyc_hi - c0), 32'd4);
    chk("to_err", 32'(err), 32'd1);
    chk("to_done", 32'(done_cnt - d0), 32'd1);
    ack_en = 1'b1;
    src[0] = 8'h5A;
    model_load(16, 1);
    run_load(1, 100, -1, 0, t);
    chk("to_err_cleared", 32'(err), 32'd0);
    chk("to_q_empty", 32'(exp_q.size()), 0);

    // reset while the write is on the bus
    sel_b = 1'b0;
    for (int i = 0; i < 4; i++) src[i] = 8'($urandom);
    model_load(0, 4);
    d0 = done_cnt;
    run_load(4, 100, -1, 1, t);
    @(negedge clk);
    chk("rst_w_cyc", 32'(a_cyc), 0);
    chk("rst_w_busy", 32'(a_busy), 0);
    chk("rst_w_err", 32'(a_err), 0);
    rst = 1'b0;
    exp_q.delete();
    c0 = cyc_hi;
    repeat (6) @(negedge clk);
    chk("rst_w_quiet", 32'(cyc_hi - c0), 0);
    chk("rst_w_no_done", 32'(done_cnt - d0), 0);

    // zero-length start
    c0 = cyc_hi;
    @(negedge clk); start = 1'b1; len = '0;
    @(negedge clk); start = 1'b0;
    chk("len0_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("len0_done_low", 32'(done), 32'd0);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_no_bus", 32'(cyc_hi - c0), 0);

    // i_start during COLLECT must not disturb the load
    for (int i = 0; i < 6; i++) src[i] = 8'($urandom);
    model_load(0, 6);
    d0 = done_cnt; w0 = wr_cnt;
    run_load(6, 100, 2, 0, t);
    repeat (3) @(negedge clk);
    chk("mid_writes", 32'(wr_cnt - w0), 32'd2);
    chk("mid_done", 32'(done_cnt - d0), 32'd1);
    chk("mid_idle", 32'(busy), 32'd0);
    chk("mid_q_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
